// File: rtl/ws2812_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_ctrl
// Brief    : Frame sequencer for a WS2812 chain. It fetches each GRB pixel
//            from memory, hands it to the bit encoder, waits for the encoder
//            to drain, then holds the reset/latch gap. Frames are launched by
//            a one-shot start or by a periodic auto-refresh timer.
//            Optional macro WS2812_FRAME_CTRL_OVERRUN_EN builds a saturating
//            counter of dropped auto-refresh requests.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS     = 8,
    parameter int LATCH_CYCLES = 1000,
    parameter int FRAME_PERIOD = 266667,
    localparam int c_aw        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    input  logic            auto_en,
    output logic            mem_rd,
    output logic [c_aw-1:0] mem_addr,
    input  logic [23:0]     mem_data,
    output logic [23:0]     pix_data,
    output logic            pix_valid,
    input  logic            pix_ready,
    input  logic            enc_idle,
    output logic            busy,
    output logic            frame_done,
    output logic [7:0]      overrun_cnt
);

    localparam int c_lw = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int c_tw = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    localparam logic [c_aw-1:0] c_last_addr  = c_aw'(NUM_LEDS - 1);
    localparam logic [c_lw-1:0] c_latch_last = c_lw'(LATCH_CYCLES - 1);
    localparam logic [c_tw-1:0] c_timer_last = c_tw'(FRAME_PERIOD - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_fetch   = 3'd1;
    localparam logic [2:0] c_st_wait    = 3'd2;
    localparam logic [2:0] c_st_present = 3'd3;
    localparam logic [2:0] c_st_drain   = 3'd4;
    localparam logic [2:0] c_st_latch   = 3'd5;

    logic [2:0]      r_state;
    logic [c_aw-1:0] r_mem_addr;
    logic [23:0]     r_pix_data;
    logic            r_mem_rd;
    logic            r_pix_valid;
    logic            r_busy;
    logic            r_frame_done;
    logic [c_lw-1:0] r_latch_cnt;
    logic [c_tw-1:0] r_timer;
    logic            r_pending;

    logic w_wrap;
    logic w_launch;

    assign w_wrap   = auto_en && (r_timer == c_timer_last);
    assign w_launch = (r_state == c_st_idle) && (start || r_pending);

    // Free-running refresh timer; a wrap leaves a single pending request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
        end else if (!auto_en) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_tw'(1);
            end
            // A wrap coinciding with a launch is a fresh request, so it wins.
            if (w_wrap) begin
                r_pending <= 1'b1;
            end else if (w_launch) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= c_st_idle;
            r_mem_addr   <= '0;
            r_pix_data   <= '0;
            r_mem_rd     <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_latch_cnt  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_launch) begin
                        r_state    <= c_st_fetch;
                        r_mem_addr <= '0;
                        r_mem_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                c_st_fetch: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= c_st_wait;
                end
                c_st_wait: begin
                    r_pix_data  <= mem_data;
                    r_pix_valid <= 1'b1;
                    r_state     <= c_st_present;
                end
                c_st_present: begin
                    if (pix_ready) begin
                        r_pix_valid <= 1'b0;
                        if (r_mem_addr == c_last_addr) begin
                            r_state <= c_st_drain;
                        end else begin
                            r_mem_addr <= r_mem_addr + c_aw'(1);
                            r_mem_rd   <= 1'b1;
                            r_state    <= c_st_fetch;
                        end
                    end
                end
                c_st_drain: begin
                    if (enc_idle) begin
                        r_latch_cnt <= '0;
                        r_state     <= c_st_latch;
                    end
                end
                c_st_latch: begin
                    if (r_latch_cnt == c_latch_last) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= c_st_idle;
                    end else begin
                        r_latch_cnt <= r_latch_cnt + c_lw'(1);
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_mem_rd    <= 1'b0;
                    r_pix_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef WS2812_FRAME_CTRL_OVERRUN_EN
    logic [7:0] r_overrun_cnt;

    // A wrap finding the request still unserved drops one refresh.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_overrun_cnt <= 8'd0;
        end else if (w_wrap && r_pending && !w_launch && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
`else
    assign overrun_cnt = 8'd0;
`endif

    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign pix_data   = r_pix_data;
    assign pix_valid  = r_pix_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_frame_ctrl
// Brief    : Directed self-checking bench for ws2812_frame_ctrl
//            (NUM_LEDS=3, LATCH_CYCLES=10, FRAME_PERIOD=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_ctrl;

    localparam int NUM_LEDS     = 3;
    localparam int LATCH_CYCLES = 10;
    localparam int FRAME_PERIOD = 100;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        pix_ready = 1'b1;
    logic        enc_idle = 1'b1;
    logic [23:0] mem_data = 24'h0;
    logic        mem_rd;
    logic [1:0]  mem_addr;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    logic [23:0] mem [0:2];

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int prev_start_cyc = 0;
    int last_hs_cyc = 0;
    int viol = 0;
    logic pv_q = 1'b0;
    logic pr_q = 1'b0;
    logic rst_q = 1'b0;
    logic [23:0] hs_data [$];
    logic [1:0]  hs_addr [$];

`ifdef WS2812_FRAME_CTRL_OVERRUN_EN
    localparam logic [7:0] EXP_OVR = 8'd1;
`else
    localparam logic [7:0] EXP_OVR = 8'd0;
`endif

    ws2812_frame_ctrl #(
        .NUM_LEDS    (NUM_LEDS),
        .LATCH_CYCLES(LATCH_CYCLES),
        .FRAME_PERIOD(FRAME_PERIOD)
    ) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .auto_en    (auto_en),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .enc_idle   (enc_idle),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun_cnt(overrun_cnt)
    );

    always #5 CLK = ~CLK;

    // Pixel memory: data valid one cycle after the read strobe, garbage otherwise.
    always @(posedge CLK) begin
        if (mem_rd && mem_addr < 2'd3) mem_data <= mem[mem_addr];
        else                           mem_data <= 24'hDEAD00;
    end

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (mem_rd && mem_addr == 2'd0) begin
            start_cnt      = start_cnt + 1;
            prev_start_cyc = start_cyc;
            start_cyc      = cyc;
        end
        if (RST_N) begin
            if (pix_valid && pix_ready) begin
                hs_data.push_back(pix_data);
                hs_addr.push_back(mem_addr);
                last_hs_cyc = cyc;
            end
            if (rst_q && pv_q && !pr_q && !pix_valid) viol = viol + 1;
        end
        pv_q  = pix_valid;
        pr_q  = pix_ready;
        rst_q = RST_N;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (!pix_valid && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(pix_valid), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int k = 0;
        while (start_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(start_cnt >= target), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [23:0] exp_d [0:2];
        exp_d[0] = 24'h112233;
        exp_d[1] = 24'h445566;
        exp_d[2] = 24'h778899;
        check({tag, "_words"}, 32'(hs_data.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < hs_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), 32'(hs_data[i]), 32'(exp_d[i]));
                check($sformatf("%s_addr%0d", tag, i), 32'(hs_addr[i]), 32'(i));
            end
        end
    endtask

    initial begin
        int d0;
        int s0;
        logic stable;

        mem[0] = 24'h112233;
        mem[1] = 24'h445566;
        mem[2] = 24'h778899;

        // Reset values
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        @(posedge CLK); #1 RST_N = 1'b1;
        repeat (5) tick();
        check("idle_no_request", 32'(busy), 32'd0);

        // Single frame with encoder always ready
        hs_data.delete(); hs_addr.delete();
        d0 = done_cnt;
        pulse_start();
        tick();
        check("s1_busy", 32'(busy), 32'd1);
        wait_done(d0 + 1, 100, "s1_done_seen");
        check_frame("s1");
        check("s1_latch_delay", 32'(done_cyc - last_hs_cyc), 32'd12);
        repeat (10) tick();
        check("s1_one_done", 32'(done_cnt - d0), 32'd1);
        check("s1_idle_after", 32'(busy), 32'd0);

        // Backpressure on pixel 1
        hs_data.delete(); hs_addr.delete();
        d0 = done_cnt;
        @(posedge CLK); #1 pix_ready = 1'b0;
        pulse_start();
        wait_valid(20, "s2_px0_valid");
        check("s2_px0_data", 32'(pix_data), 32'h112233);
        @(posedge CLK); #1 pix_ready = 1'b1;
        @(posedge CLK); #1 pix_ready = 1'b0;
        wait_valid(20, "s2_px1_valid");
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!(pix_valid && pix_data == 24'h445566 && mem_addr == 2'd1)) stable = 1'b0;
            tick();
        end
        check("s2_hold_stable", 32'(stable), 32'd1);
        @(posedge CLK); #1 pix_ready = 1'b1;
        wait_done(d0 + 1, 100, "s2_done_seen");
        check_frame("s2");

        // Start while busy is ignored
        hs_data.delete(); hs_addr.delete();
        d0 = done_cnt;
        s0 = start_cnt;
        @(posedge CLK); #1 pix_ready = 1'b0;
        pulse_start();
        wait_valid(20, "s3_valid");
        pulse_start();
        @(posedge CLK); #1 pix_ready = 1'b1;
        begin
            int k = 0;
            while (hs_data.size() < 3 && k < 50) begin
                tick();
                k++;
            end
        end
        repeat (4) tick();
        check("s3_busy_in_latch", 32'(busy), 32'd1);
        pulse_start();
        wait_done(d0 + 1, 60, "s3_done_seen");
        repeat (40) tick();
        check("s3_one_done", 32'(done_cnt - d0), 32'd1);
        check("s3_one_start", 32'(start_cnt - s0), 32'd1);

        // Auto refresh
        s0 = start_cnt;
        @(posedge CLK); #1 auto_en = 1'b1;
        wait_starts(s0 + 1, 150, "s4_first_start");
        wait_starts(s0 + 2, 150, "s4_second_start");
        check("s4_period_a", 32'(start_cyc - prev_start_cyc), 32'd100);
        wait_starts(s0 + 3, 150, "s4_third_start");
        check("s4_period_b", 32'(start_cyc - prev_start_cyc), 32'd100);
        d0 = done_cnt;
        s0 = start_cnt;
        @(posedge CLK); #1 enc_idle = 1'b0;
        repeat (250) @(posedge CLK);
        #1 enc_idle = 1'b1;
        check("s4_no_start_stalled", 32'(start_cnt - s0), 32'd0);
        check("s4_overrun", 32'(overrun_cnt), 32'(EXP_OVR));
        wait_starts(s0 + 1, 40, "s4_pending_start");
        @(posedge CLK); #1 auto_en = 1'b0;
        repeat (60) tick();
        check("s4_pending_once", 32'(start_cnt - s0), 32'd1);
        check("s4_two_dones", 32'(done_cnt - d0), 32'd2);
        check("s4_overrun_hold", 32'(overrun_cnt), 32'(EXP_OVR));

        // Reset in the middle of a frame
        hs_data.delete(); hs_addr.delete();
        @(posedge CLK); #1 pix_ready = 1'b0;
        pulse_start();
        wait_valid(20, "s5_valid");
        d0 = done_cnt;
        @(posedge CLK); #1 RST_N = 1'b0;
        tick();
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_mem_rd", 32'(mem_rd), 32'd0);
        check("s5_pix_valid", 32'(pix_valid), 32'd0);
        check("s5_frame_done", 32'(frame_done), 32'd0);
        check("s5_mem_addr", 32'(mem_addr), 32'd0);
        check("s5_pix_data", 32'(pix_data), 32'd0);
        check("s5_overrun", 32'(overrun_cnt), 32'd0);
        repeat (2) tick();
        @(posedge CLK); #1 RST_N = 1'b1; pix_ready = 1'b1;
        s0 = start_cnt;
        repeat (30) tick();
        check("s5_no_done", 32'(done_cnt - d0), 32'd0);
        check("s5_waits_request", 32'(start_cnt - s0), 32'd0);
        hs_data.delete(); hs_addr.delete();
        pulse_start();
        wait_done(d0 + 1, 100, "s5_done_seen");
        check_frame("s5");

        check("valid_never_dropped", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
